// File: rtl/accumulate_to_7segment_nd.sv
// Windowed accumulator of qualified beats into a D-digit decimal sum, shown on
// D seven-segment glyphs through a multi-cycle double-dabble converter.
module accumulate_to_7segment_nd #(
    parameter int N        = 10,
    parameter int W        = 3,
    parameter int D        = 2,
    parameter int OVF_MODE = 0,
    parameter int BLANK    = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              s_valid,
    input  logic [W-1:0]      s_data,
    output logic [D-1:0][6:0] m_data,
    output logic              m_update,
    output logic              m_ovf,
    output logic              m_window_done
);
    localparam int POW   = 10 ** D;
    localparam int SUM_W = $clog2(POW);
    localparam int CW    = $clog2(N);
    localparam int IW    = $clog2(SUM_W + 1);

    localparam logic [SUM_W:0]   LIM_X = (SUM_W+1)'(POW - 1);
    localparam logic [SUM_W-1:0] POW_T = SUM_W'(POW);
    localparam logic [CW-1:0]    LAST  = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h7E;
            4'd1:    seg7 = 7'h30;
            4'd2:    seg7 = 7'h6D;
            4'd3:    seg7 = 7'h79;
            4'd4:    seg7 = 7'h33;
            4'd5:    seg7 = 7'h5B;
            4'd6:    seg7 = 7'h5F;
            4'd7:    seg7 = 7'h70;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h7B;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic [SUM_W-1:0] sum;
    logic [CW-1:0]    cnt;
    logic [SUM_W:0]   nxt;
    logic [SUM_W-1:0] wrap;

    assign nxt  = {1'b0, sum} + {{(SUM_W+1-W){1'b0}}, s_data};
    // Low bits of nxt - 10^D; nxt never exceeds 2*LIMIT so the result fits.
    assign wrap = nxt[SUM_W-1:0] - POW_T;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum           <= '0;
            cnt           <= '0;
            m_ovf         <= 1'b0;
            m_window_done <= 1'b0;
        end else begin
            m_window_done <= 1'b0;
            if (clear) begin
                sum   <= '0;
                cnt   <= '0;
                m_ovf <= 1'b0;
            end else if (s_valid) begin
                if (cnt == LAST) begin
                    // Closing beat's data is dropped; window end beats overflow.
                    sum           <= '0;
                    cnt           <= '0;
                    m_ovf         <= 1'b0;
                    m_window_done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (nxt <= LIM_X) begin
                        sum <= nxt[SUM_W-1:0];
                    end else begin
                        m_ovf <= 1'b1;
                        case (OVF_MODE)
                            1:       sum <= LIM_X[SUM_W-1:0];
                            2:       sum <= wrap;
                            default: sum <= '0;
                        endcase
                    end
                end
            end
        end
    end

    state_t           st;
    logic [SUM_W-1:0] snap;
    logic [SUM_W-1:0] last_shown;
    logic [4*D-1:0]   bcd;
    logic [4*D-1:0]   bcd_adj;
    logic [IW-1:0]    i;
    logic [D-1:0][6:0] glyph_nxt;
    logic             lead_zero;

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < D; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Walk from the top digit down so lead_zero covers digits k..D-1.
    always_comb begin
        glyph_nxt = '0;
        lead_zero = 1'b1;
        for (int k = D - 1; k >= 0; k--) begin
            lead_zero    = lead_zero & (bcd[4*k +: 4] == 4'd0);
            glyph_nxt[k] = (BLANK != 0 && k > 0 && lead_zero) ? 7'h00
                                                               : seg7(bcd[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st         <= IDLE;
            snap       <= '0;
            last_shown <= '0;
            bcd        <= '0;
            i          <= '0;
            m_update   <= 1'b0;
            for (int k = 0; k < D; k++)
                m_data[k] <= (BLANK != 0 && k > 0) ? 7'h00 : 7'h7E;
        end else begin
            m_update <= 1'b0;
            case (st)
                IDLE: begin
                    if (sum != last_shown) begin
                        snap <= sum;
                        bcd  <= '0;
                        i    <= '0;
                        st   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // snap rotates rather than shifts, so after SUM_W steps it
                    // holds the converted value again for last_shown.
                    bcd  <= {bcd_adj[4*D-2:0], snap[SUM_W-1]};
                    snap <= {snap[SUM_W-2:0], snap[SUM_W-1]};
                    i    <= i + IW'(1);
                    if (i == IW'(SUM_W - 1))
                        st <= LOAD;
                end
                LOAD: begin
                    m_data     <= glyph_nxt;
                    last_shown <= snap;
                    m_update   <= 1'b1;
                    st         <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
